// File: rtl/fpu_bus_master.sv
// Host-side bus master for a byte-wide FPU: writes two 32-bit operands and an opcode,
// waits for end-of-command (bounded by a timeout), reads back a 32-bit result, then acks.
module fpu_bus_master #(
    parameter int STROBE_CYCLES = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [5:0]  addr,
    output logic [7:0]  databus_out,
    input  logic [7:0]  databus_in,
    output logic        cs,
    output logic        rd,
    output logic        wr,
    input  logic        cmd_end,
    output logic        end_ack
);

    localparam int SW = $clog2(STROBE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STRB_LAST = SW'(STROBE_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_WR_SETUP  = 4'd1;
    localparam logic [3:0] ST_WR_STROBE = 4'd2;
    localparam logic [3:0] ST_WR_HOLD   = 4'd3;
    localparam logic [3:0] ST_WAIT_END  = 4'd4;
    localparam logic [3:0] ST_RD_SETUP  = 4'd5;
    localparam logic [3:0] ST_RD_STROBE = 4'd6;
    localparam logic [3:0] ST_RD_HOLD   = 4'd7;
    localparam logic [3:0] ST_ACK       = 4'd8;
    localparam logic [3:0] ST_DONE      = 4'd9;

    localparam logic [3:0] IDX_LAST_WR  = 4'd8;
    localparam logic [3:0] IDX_FIRST_RD = 4'd9;
    localparam logic [3:0] IDX_LAST_RD  = 4'd12;

    logic [3:0]    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [SW-1:0] strb_q, strb_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   result_q, result_d;
    logic          err_q, err_d;
    logic [7:0]    wr_byte;

    // Register index 0..7 maps to operand bytes little-endian; index 8 carries the opcode.
    always_comb begin
        wr_byte = {4'h0, op_q};
        case (idx_q)
            4'd0: wr_byte = op_a_q[7:0];
            4'd1: wr_byte = op_a_q[15:8];
            4'd2: wr_byte = op_a_q[23:16];
            4'd3: wr_byte = op_a_q[31:24];
            4'd4: wr_byte = op_b_q[7:0];
            4'd5: wr_byte = op_b_q[15:8];
            4'd6: wr_byte = op_b_q[23:16];
            4'd7: wr_byte = op_b_q[31:24];
            default: wr_byte = {4'h0, op_q};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        strb_d   = strb_q;
        wait_d   = wait_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = op_a;
                    op_b_d  = op_b;
                    op_d    = op;
                    err_d   = 1'b0;
                    idx_d   = 4'd0;
                    state_d = ST_WR_SETUP;
                end
            end
            ST_WR_SETUP: begin
                strb_d  = '0;
                state_d = ST_WR_STROBE;
            end
            ST_WR_STROBE: begin
                if (strb_q == STRB_LAST) begin
                    strb_d  = '0;
                    state_d = ST_WR_HOLD;
                end else begin
                    strb_d = strb_q + 1'b1;
                end
            end
            ST_WR_HOLD: begin
                if (idx_q == IDX_LAST_WR) begin
                    wait_d  = '0;
                    state_d = ST_WAIT_END;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_WR_SETUP;
                end
            end
            ST_WAIT_END: begin
                // cmd_end wins over the timeout on the final allowed cycle.
                if (cmd_end) begin
                    idx_d   = IDX_FIRST_RD;
                    state_d = ST_RD_SETUP;
                end else if (wait_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RD_SETUP: begin
                strb_d  = '0;
                state_d = ST_RD_STROBE;
            end
            ST_RD_STROBE: begin
                if (strb_q == STRB_LAST) begin
                    strb_d  = '0;
                    state_d = ST_RD_HOLD;
                    case (idx_q)
                        4'd9:    result_d[7:0]   = databus_in;
                        4'd10:   result_d[15:8]  = databus_in;
                        4'd11:   result_d[23:16] = databus_in;
                        default: result_d[31:24] = databus_in;
                    endcase
                end else begin
                    strb_d = strb_q + 1'b1;
                end
            end
            ST_RD_HOLD: begin
                if (idx_q == IDX_LAST_RD) begin
                    state_d = ST_ACK;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_RD_SETUP;
                end
            end
            ST_ACK:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            strb_q   <= '0;
            wait_q   <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            strb_q   <= strb_d;
            wait_q   <= wait_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Bus pins decode straight from registered state so reset takes effect immediately.
    always_comb begin
        cs          = 1'b1;
        rd          = 1'b1;
        wr          = 1'b1;
        addr        = 6'h00;
        databus_out = 8'h00;
        case (state_q)
            ST_WR_SETUP, ST_WR_HOLD: begin
                cs          = 1'b0;
                addr        = {2'b00, idx_q};
                databus_out = wr_byte;
            end
            ST_WR_STROBE: begin
                cs          = 1'b0;
                wr          = 1'b0;
                addr        = {2'b00, idx_q};
                databus_out = wr_byte;
            end
            ST_RD_SETUP, ST_RD_HOLD: begin
                cs   = 1'b0;
                addr = {2'b00, idx_q};
            end
            ST_RD_STROBE: begin
                cs   = 1'b0;
                rd   = 1'b0;
                addr = {2'b00, idx_q};
            end
            default: begin
                cs = 1'b1;
            end
        endcase
    end

    assign end_ack = (state_q == ST_ACK);
    assign done    = (state_q == ST_DONE);
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;
    assign result  = result_q;

endmodule
